// File: rtl/l2_port_arbiter.sv
// Shares one L2 request/response port between the L1I and L1D caches: round-robin
// into a single registered request slot, in-order source-ID FIFO for read responses.
module l2_port_arbiter #(
  parameter int PADDR_BITS      = 22,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_in,
  input  logic                                   rst_N_in,
  input  logic                                   i_valid_in,
  output logic                                   i_ready_out,
  input  logic [PADDR_BITS-1:0]                  i_addr_in,
  input  logic [63:0]                            i_value_in,
  input  logic                                   i_we_in,
  input  logic                                   d_valid_in,
  output logic                                   d_ready_out,
  input  logic [PADDR_BITS-1:0]                  d_addr_in,
  input  logic [63:0]                            d_value_in,
  input  logic                                   d_we_in,
  output logic                                   lc_valid_out,
  input  logic                                   lc_ready_in,
  output logic [PADDR_BITS-1:0]                  lc_addr_out,
  output logic [63:0]                            lc_value_out,
  output logic                                   lc_we_out,
  input  logic                                   lc_valid_in,
  output logic                                   lc_ready_out,
  input  logic [PADDR_BITS-1:0]                  lc_addr_in,
  input  logic [63:0]                            lc_value_in,
  output logic                                   i_resp_valid_out,
  input  logic                                   i_resp_ready_in,
  output logic                                   d_resp_valid_out,
  input  logic                                   d_resp_ready_in,
  output logic [PADDR_BITS-1:0]                  resp_addr_out,
  output logic [63:0]                            resp_value_out,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_out,
  output logic                                   orphan_err_out
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;

  logic                         lc_valid_r;
  logic [PADDR_BITS-1:0]        lc_addr_r;
  logic [63:0]                  lc_value_r;
  logic                         lc_we_r;
  src_e                         last_grant_r;
  logic [MAX_OUTSTANDING-1:0]   fifo_src_r;
  logic [PTR_W-1:0]             head_r;
  logic [PTR_W-1:0]             tail_r;
  logic [CNT_W-1:0]             count_r;
  logic                         orphan_r;

  logic                         slot_free_s;
  logic                         fifo_full_s;
  logic                         fifo_empty_s;
  logic                         i_elig_s;
  logic                         d_elig_s;
  logic                         grant_i_s;
  logic                         grant_d_s;
  logic                         grant_any_s;
  logic                         push_s;
  logic                         pop_s;
  logic                         head_is_d_s;
  logic                         i_resp_valid_s;
  logic                         d_resp_valid_s;
  logic                         lc_ready_s;

  assign slot_free_s  = !lc_valid_r || lc_ready_in;
  // A pop in the same cycle deliberately does not make room for a new read.
  assign fifo_full_s  = (count_r == FULL_COUNT);
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign i_elig_s     = i_valid_in && slot_free_s && (i_we_in || !fifo_full_s);
  assign d_elig_s     = d_valid_in && slot_free_s && (d_we_in || !fifo_full_s);
  assign grant_any_s  = grant_i_s || grant_d_s;
  assign push_s       = (grant_i_s && !i_we_in) || (grant_d_s && !d_we_in);
  assign pop_s        = lc_valid_in && lc_ready_s && !fifo_empty_s;
  assign head_is_d_s  = fifo_src_r[head_r];

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (i_elig_s && d_elig_s) begin
      if (last_grant_r == SRC_I) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = 1'b1;
      end
    end else if (i_elig_s) begin
      grant_i_s = 1'b1;
    end else if (d_elig_s) begin
      grant_d_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Response steering to the FIFO head's source; with nothing outstanding responses are dropped.
  always_comb begin
    i_resp_valid_s = 1'b0;
    d_resp_valid_s = 1'b0;
    lc_ready_s     = 1'b1;
    if (fifo_empty_s) begin
      lc_ready_s = 1'b1;
    end else if (head_is_d_s) begin
      d_resp_valid_s = lc_valid_in;
      lc_ready_s     = d_resp_ready_in;
    end else begin
      i_resp_valid_s = lc_valid_in;
      lc_ready_s     = i_resp_ready_in;
    end
  end

  // Output request slot; holds stable while L2 back-pressures.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      lc_valid_r   <= 1'b0;
      lc_addr_r    <= {PADDR_BITS{1'b0}};
      lc_value_r   <= 64'h0;
      lc_we_r      <= 1'b0;
      last_grant_r <= SRC_I;
    end else if (grant_i_s) begin
      lc_valid_r   <= 1'b1;
      lc_addr_r    <= i_addr_in;
      lc_value_r   <= i_value_in;
      lc_we_r      <= i_we_in;
      last_grant_r <= SRC_I;
    end else if (grant_d_s) begin
      lc_valid_r   <= 1'b1;
      lc_addr_r    <= d_addr_in;
      lc_value_r   <= d_value_in;
      lc_we_r      <= d_we_in;
      last_grant_r <= SRC_D;
    end else if (slot_free_s) begin
      lc_valid_r   <= 1'b0;
    end else begin
      lc_valid_r   <= lc_valid_r;
    end
  end

  // Source-ID FIFO for reads in flight plus the sticky orphan flag.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      fifo_src_r <= {MAX_OUTSTANDING{1'b0}};
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      orphan_r   <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_src_r[tail_r] <= grant_d_s;
        tail_r             <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
      if (lc_valid_in && fifo_empty_s) begin
        orphan_r <= 1'b1;
      end
    end
  end

  assign i_ready_out      = grant_i_s;
  assign d_ready_out      = grant_d_s;
  assign lc_valid_out     = lc_valid_r;
  assign lc_addr_out      = lc_addr_r;
  assign lc_value_out     = lc_value_r;
  assign lc_we_out        = lc_we_r;
  assign lc_ready_out     = lc_ready_s;
  assign i_resp_valid_out = i_resp_valid_s;
  assign d_resp_valid_out = d_resp_valid_s;
  assign resp_addr_out    = lc_addr_in;
  assign resp_value_out   = lc_value_in;
  assign outstanding_out  = count_r;
  assign orphan_err_out   = orphan_r;

endmodule
